// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 key-expansion constants, FSM state type and GF(2^8) multiply
// Contents: NK/NR/NW sizes, RCON round-constant table, state_t enum, gf_mul()
package aes_pkg;
    localparam int NK = 4;
    localparam int NR = 10;
    localparam int NW = 44;
    localparam logic [0:NR-1][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational 8-bit AES S-box
// Ports: a (in, 8) byte to substitute; y (out, 8) substituted byte
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] inv;
    logic [7:0] p;
    // multiplicative inverse as a^254 (square-and-multiply); 0 maps to 0
    always_comb begin
        inv = 8'h01;
        p   = a;
        for (int k = 1; k < 8; k++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
    end
    assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

// File: rtl/key_scheduler.sv
// key_scheduler: iterative FIPS-197 AES-128 key expansion into 44 round-key words
// Ports: clk (in) clock; n_rst (in) async active-low reset; start (in) expand key_in;
//        key_in (in, 128) cipher key, [127:96]=w[0]; key_schedule (out, [0:43][31:0]) w[0..43];
//        busy (out) expansion running; key_valid (out) key_schedule complete
// Build option: define KEY_SCHED_FAST_EN to expand a whole round (4 words) per cycle.
module key_scheduler
    import aes_pkg::*;
(
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [127:0]        key_in,
    output logic [0:43][31:0]   key_schedule,
    output logic                busy,
    output logic                key_valid
);
`ifdef KEY_SCHED_FAST_EN
    localparam int LANES = 4;
`else
    localparam int LANES = 1;
`endif
    state_t      state, state_nx;
    logic [5:0]  cnt;
    logic [31:0] lane_w [LANES];
    logic        last;
    logic        accept;
    // each lane produces w[cnt+l]; lanes chain so lane l sees lane l-1 as w[i-1]
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [5:0]  idx;
        logic [31:0] prev, rot, sub, temp;
        assign idx = cnt + 6'(l);
        if (l == 0) begin : g_first
            assign prev = key_schedule[cnt - 6'd1];
        end else begin : g_chain
            assign prev = lane_w[l-1];
        end
        assign rot = {prev[23:0], prev[31:24]};
        for (genvar b = 0; b < 4; b++) begin : g_sb
            aes_sbox u_sbox (.a(rot[8*b +: 8]), .y(sub[8*b +: 8]));
        end
        assign temp = (idx[1:0] == 2'd0) ? sub ^ {RCON[idx[5:2] - 4'd1], 24'h0} : prev;
        assign lane_w[l] = key_schedule[idx - 6'd4] ^ temp;
    end
    assign last   = (cnt == 6'(NW - LANES));
    assign accept = start && (state != EXPAND);
    always_comb begin
        state_nx = accept ? EXPAND : (state == EXPAND && last) ? DONE : state;
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            key_schedule <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                for (int k = 0; k < NK; k++) key_schedule[k] <= key_in[127-32*k -: 32];
                cnt <= 6'(NK);
            end else if (state == EXPAND) begin
                for (int k = 0; k < LANES; k++) key_schedule[cnt + 6'(k)] <= lane_w[k];
                cnt <= last ? 6'(NW - 1) : cnt + 6'(LANES);
            end
        end
    end
    assign busy      = (state == EXPAND);
    assign key_valid = (state == DONE);
endmodule

// File: tb/tb_key_scheduler.sv
// tb_key_scheduler: randomized self-checking bench for key_scheduler against a behavioural expansion model
module tb_key_scheduler;
`ifdef KEY_SCHED_FAST_EN
    localparam int LAT = 10;
`else
    localparam int LAT = 40;
`endif
    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             start = 1'b0;
    logic [127:0]     key_in = '0;
    logic [0:43][31:0] key_schedule;
    logic             busy, key_valid;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    logic [7:0] sb [256];

    key_scheduler dut (.clk(clk), .n_rst(n_rst), .start(start), .key_in(key_in),
                       .key_schedule(key_schedule), .busy(busy), .key_valid(key_valid));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // S-box table from the generator walk: p runs over all nonzero elements via x*3, q tracks p^-1
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q ^= q << 1;
            q ^= q << 2;
            q ^= q << 4;
            if (q[7]) q ^= 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [0:43][31:0] model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [0:43][31:0] r;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) r[i] = w[i];
        return r;
    endfunction

    task automatic pulse_start(input logic [127:0] k);
        @(negedge clk);
        key_in = k;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        key_in = rand128();
        t0 = cyc;
    endtask

    // key_in is scrambled every cycle to show it is not re-sampled
    task automatic wait_valid();
        while (!key_valid && (cyc - t0) < 200) begin
            @(negedge clk);
            key_in = rand128();
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (key_schedule !== '0 || busy !== 1'b0 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b valid=%b ks_nonzero=%b required busy=0 valid=0 ks=0",
                     busy, key_valid, key_schedule != '0);
        end
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_fips();
        logic [127:0] k1, k2;
        k1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        k2 = 128'h6c756b65696d796f7572666174686572;
        pulse_start(k1);
        checks++;
        if (busy !== 1'b1 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL fips1_busy: busy=%b valid=%b required 1/0", busy, key_valid);
        end
        wait_valid();
        checks++;
        if (cyc - t0 !== LAT || key_valid !== 1'b1) begin
            errors++;
            $display("FAIL fips1_latency: got %0d cycles valid=%b required %0d", cyc - t0, key_valid, LAT);
        end
        checks++;
        if (key_schedule[4] !== 32'ha0fafe17 || key_schedule[43] !== 32'hb6630ca6) begin
            errors++;
            $display("FAIL fips1_words: w4=%h w43=%h required a0fafe17 b6630ca6", key_schedule[4], key_schedule[43]);
        end
        checks++;
        if (key_schedule !== model(k1)) begin
            errors++;
            $display("FAIL fips1_schedule: got %h required %h", key_schedule, model(k1));
        end
        repeat (5) begin
            @(negedge clk);
            key_in = rand128();
        end
        checks++;
        if (key_valid !== 1'b1 || busy !== 1'b0 || key_schedule !== model(k1)) begin
            errors++;
            $display("FAIL done_hold: valid=%b busy=%b required 1/0 with unchanged schedule", key_valid, busy);
        end
        pulse_start(k2);
        wait_valid();
        checks++;
        if (key_schedule[4] !== 32'h28382bf7 || key_schedule[23] !== 32'hf1afd010 ||
            key_schedule[43] !== 32'ha4405979) begin
            errors++;
            $display("FAIL key2_words: w4=%h w23=%h w43=%h required 28382bf7 f1afd010 a4405979",
                     key_schedule[4], key_schedule[23], key_schedule[43]);
        end
        checks++;
        if (key_schedule !== model(k2) || cyc - t0 !== LAT) begin
            errors++;
            $display("FAIL key2_schedule: latency %0d required %0d; got %h required %h",
                     cyc - t0, LAT, key_schedule, model(k2));
        end
    endtask

    task automatic test_ignored_restart();
        logic [127:0] ka, kb;
        ka = rand128();
        kb = ~ka;
        pulse_start(ka);
        repeat (LAT / 2 - 1) @(negedge clk);
        key_in = kb;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        checks++;
        if (busy !== 1'b1 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL restart_busy: busy=%b valid=%b required 1/0", busy, key_valid);
        end
        wait_valid();
        checks++;
        if (cyc - t0 !== LAT || key_schedule !== model(ka)) begin
            errors++;
            $display("FAIL restart_ignored: latency %0d required %0d; got %h required %h",
                     cyc - t0, LAT, key_schedule, model(ka));
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] k;
        int stop;
        stop = (LAT > 18) ? 15 : LAT - 3;
        pulse_start(rand128());
        repeat (stop - 1) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if (key_schedule !== '0 || busy !== 1'b0 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: busy=%b valid=%b ks_nonzero=%b required all 0",
                     busy, key_valid, key_schedule != '0);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: busy=%b valid=%b required 0/0", busy, key_valid);
        end
        k = rand128();
        n_rst  = 1'b1;
        key_in = k;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        t0 = cyc;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL first_edge_start: busy=%b required 1", busy);
        end
        wait_valid();
        checks++;
        if (cyc - t0 !== LAT || key_schedule !== model(k)) begin
            errors++;
            $display("FAIL after_reset: latency %0d required %0d; got %h required %h",
                     cyc - t0, LAT, key_schedule, model(k));
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] k;
        for (int n = 0; n < 4; n++) begin
            k = rand128();
            pulse_start(k);
            checks++;
            if (key_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_drop_%0d: valid=%b busy=%b required 0/1", n, key_valid, busy);
            end
            wait_valid();
            checks++;
            if (cyc - t0 !== LAT || key_schedule !== model(k)) begin
                errors++;
                $display("FAIL b2b_schedule_%0d: latency %0d required %0d; got %h required %h",
                         n, cyc - t0, LAT, key_schedule, model(k));
            end
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips();
        test_ignored_restart();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
